compare_arbiter: RTL and testbench

COMPARE_ARBITER -- requirements
Module: compare_arbiter

---
 rtl/compare_arbiter.sv | 119 +++++++++++
 tb/tb_compare_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/compare_arbiter.sv
// rtl/compare_arbiter.sv - round-robin arbiter feeding a single 4-bit unsigned comparator
// Four requesters share one compare slot; the result is held until the consumer acknowledges it.
module compare_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] a_bus,
    input  logic [15:0] b_bus,
    output logic [3:0]  grant,
    output logic        busy,
    output logic [2:0]  R,
    output logic        r_valid,
    output logic [1:0]  r_id,
    input  logic        r_ack,
    output logic [7:0]  done_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  grant_q;
    logic        busy_q;
    logic [2:0]  r_q;
    logic        r_valid_q;
    logic [1:0]  r_id_q;
    logic [7:0]  done_cnt_q;
    logic [1:0]  last_q;
    logic [1:0]  win_q;

    logic        pick_found;
    logic [1:0]  pick_idx;
    logic [1:0]  cand;
    logic [3:0]  a_sel;
    logic [3:0]  b_sel;
    logic [2:0]  cmp_res;

    // Search starts one past the last winner, so the last winner is tried last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        cand       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign a_sel   = a_bus[{win_q, 2'b00} +: 4];
    assign b_sel   = b_bus[{win_q, 2'b00} +: 4];
    assign cmp_res = {(a_sel > b_sel), (a_sel == b_sel), (a_sel < b_sel)};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 4'd0;
            busy_q     <= 1'b0;
            r_q        <= 3'b000;
            r_valid_q  <= 1'b0;
            r_id_q     <= 2'd0;
            done_cnt_q <= 8'd0;
            last_q     <= 2'd3;
            win_q      <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= 4'b0001 << pick_idx;
                        win_q   <= pick_idx;
                        last_q  <= pick_idx;
                        busy_q  <= 1'b1;
                        state_q <= CMP;
                    end else begin
                        grant_q <= 4'd0;
                        busy_q  <= 1'b0;
                    end
                end
                CMP: begin
                    r_q       <= cmp_res;
                    r_id_q    <= win_q;
                    r_valid_q <= 1'b1;
                    grant_q   <= 4'd0;
                    state_q   <= DONE;
                end
                DONE: begin
                    // New requests wait for IDLE even when ack arrives alongside them.
                    if (r_ack) begin
                        r_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                        if (done_cnt_q != 8'hFF) begin
                            done_cnt_q <= done_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    grant_q   <= 4'd0;
                    busy_q    <= 1'b0;
                    r_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign busy     = busy_q;
    assign R        = r_q;
    assign r_valid  = r_valid_q;
    assign r_id     = r_id_q;
    assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_compare_arbiter.sv
// tb/tb_compare_arbiter.sv - directed vector bench for compare_arbiter
module tb_compare_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] a_bus;
    logic [15:0] b_bus;
    logic [3:0]  grant;
    logic        busy;
    logic [2:0]  R;
    logic        r_valid;
    logic [1:0]  r_id;
    logic        r_ack;
    logic [7:0]  done_cnt;

    int checks;
    int failures;
    int exp_cnt;

    compare_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .a_bus    (a_bus),
        .b_bus    (b_bus),
        .grant    (grant),
        .busy     (busy),
        .R        (R),
        .r_valid  (r_valid),
        .r_id     (r_id),
        .r_ack    (r_ack),
        .done_cnt (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  grant;
        logic [2:0]  r;
        logic [1:0]  id;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        req   = v.req;
        a_bus = v.a;
        b_bus = v.b;
        step();
        chk("vec_grant", int'(grant), int'(v.grant));
        chk("vec_busy", int'(busy), 1);
        req = 4'd0;
        step();
        chk("vec_r_valid", int'(r_valid), 1);
        chk("vec_R", int'(R), int'(v.r));
        chk("vec_r_id", int'(r_id), int'(v.id));
        chk("vec_grant_done", int'(grant), 0);
        r_ack = 1'b1;
        step();
        exp_cnt++;
        r_ack = 1'b0;
        chk("vec_r_valid_drop", int'(r_valid), 0);
        chk("vec_done_cnt", int'(done_cnt), exp_cnt);
    endtask

    initial begin
        logic [3:0] fair_exp[5];
        checks   = 0;
        failures = 0;
        exp_cnt  = 0;
        rst   = 1'b1;
        req   = 4'd0;
        a_bus = 16'd0;
        b_bus = 16'd0;
        r_ack = 1'b0;

        vecs[0] = '{4'b0001, 16'h0009, 16'h0003, 4'b0001, 3'b100, 2'd0};
        vecs[1] = '{4'b0100, 16'h4F12, 16'hBF34, 4'b0100, 3'b010, 2'd2};
        vecs[2] = '{4'b0100, 16'h30A5, 16'h1F27, 4'b0100, 3'b001, 2'd2};
        vecs[3] = '{4'b0100, 16'h2F81, 16'hE07C, 4'b0100, 3'b100, 2'd2};
        vecs[4] = '{4'b1010, 16'h7123, 16'h8456, 4'b1000, 3'b001, 2'd3};
        vecs[5] = '{4'b1010, 16'hF06F, 16'h0060, 4'b0010, 3'b010, 2'd1};
        vecs[6] = '{4'b0011, 16'h000D, 16'h000E, 4'b0001, 3'b001, 2'd0};
        vecs[7] = '{4'b1111, 16'h0010, 16'h0000, 4'b0010, 3'b100, 2'd1};

        step();
        step();
        rst = 1'b0;
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_R", int'(R), 0);
        chk("rst_r_valid", int'(r_valid), 0);
        chk("rst_r_id", int'(r_id), 0);
        chk("rst_done_cnt", int'(done_cnt), 0);

        // Idle with no request, stray ack ignored
        r_ack = 1'b1;
        step();
        step();
        r_ack = 1'b0;
        chk("idle_grant", int'(grant), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_ack_cnt", int'(done_cnt), 0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: last winner is 1, so requester 2 wins first
        req   = 4'b0110;
        a_bus = 16'h0900;
        b_bus = 16'h0200;
        step();
        chk("bp_grant", int'(grant), 4'b0100);
        step();
        chk("bp_R0", int'(R), 3'b100);
        a_bus = 16'h0000;
        b_bus = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_r_valid", int'(r_valid), 1);
            chk("bp_R", int'(R), 3'b100);
            chk("bp_r_id", int'(r_id), 2);
            chk("bp_grant0", int'(grant), 0);
            chk("bp_busy", int'(busy), 1);
        end
        r_ack = 1'b1;
        step();
        exp_cnt++;
        r_ack = 1'b0;
        chk("bp_r_valid_drop", int'(r_valid), 0);
        chk("bp_done_cnt", int'(done_cnt), exp_cnt);
        step();
        chk("bp_next_grant", int'(grant), 4'b0010);
        step();
        chk("bp_next_valid", int'(r_valid), 1);

        // Reset in DONE with a simultaneous ack
        rst   = 1'b1;
        r_ack = 1'b1;
        step();
        rst   = 1'b0;
        r_ack = 1'b0;
        req   = 4'b0000;
        exp_cnt = 0;
        chk("mid_rst_grant", int'(grant), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_R", int'(R), 0);
        chk("mid_rst_r_valid", int'(r_valid), 0);
        chk("mid_rst_r_id", int'(r_id), 0);
        chk("mid_rst_cnt", int'(done_cnt), 0);
        req = 4'b0011;
        step();
        chk("post_rst_grant", int'(grant), 4'b0001);
        step();
        r_ack = 1'b1;
        step();
        exp_cnt++;
        chk("post_rst_cnt", int'(done_cnt), exp_cnt);

        // Fairness with req held and ack held, continuing after winner 0
        fair_exp[0] = 4'b0010;
        fair_exp[1] = 4'b0100;
        fair_exp[2] = 4'b1000;
        fair_exp[3] = 4'b0001;
        fair_exp[4] = 4'b0010;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("fair_grant", int'(grant), int'(fair_exp[i]));
            step();
            chk("fair_gap_valid", int'(r_valid), 1);
            chk("fair_gap_grant", int'(grant), 0);
            step();
            exp_cnt++;
            chk("fair_idle_grant", int'(grant), 0);
        end
        chk("fair_cnt", int'(done_cnt), exp_cnt);

        // Saturation over 260 transactions from a fresh reset
        req   = 4'b0000;
        r_ack = 1'b0;
        rst   = 1'b1;
        step();
        rst   = 1'b0;
        req   = 4'b0001;
        r_ack = 1'b1;
        for (int i = 0; i < 254 * 3; i++) begin
            step();
        end
        chk("sat_254", int'(done_cnt), 254);
        for (int i = 0; i < 6 * 3; i++) begin
            step();
        end
        chk("sat_255", int'(done_cnt), 255);
        req   = 4'b0000;
        r_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
